result_checker: RTL and testbench
=================================

# result_checker

Synthesizable end-of-test checker on the CPU memory bus, directly downstream of the core's memory interface. Snoops every write, captures the last byte written to a designated result address, and after a fixed run window registers a pass/fail verdict. Replaces the behavioural end-of-run assertion so Suite A regressions (e.g. cmp/beq/bne, result 8'h7F at address 21) can self-check on silicon or in gate-level simulation.

## Interface
Parameters:
- RESULT_ADDR, 16'h0015: bus address whose writes are captured.
- EXPECTED, 8'h7F: value the final captured byte must equal.
- RUN_CYCLES, 16'd195: length of the run window in ph1 cycles, 1..65535.

Ports:
- ph1  in  1  single clock; all state updates on rising edge.
- reset_b  in  1  one clock; reset is asynchronous and active-low.
- address  in  16  CPU memory address.
- data  in  8  CPU write data, valid when memwrite=1.
- memwrite  in  1  write strobe, sampled on ph1 rising edge.
- done  out  1  verdict available; sticky until reset.
- pass  out  1  done and verdict good.
- fail  out  1  done and verdict bad.
- captured  out  8  last byte written to RESULT_ADDR.
- seen  out  1  at least one write to RESULT_ADDR occurred.
- write_count  out  8  number of writes to RESULT_ADDR, saturating at 8'hFF.

## Operation
- States: IDLE, RUN, DONE.
- reset_b low (any time, async): state IDLE; cycle counter 0; done, pass, fail, seen 0; captured 8'h00; write_count 0.
- IDLE -> RUN on first ph1 edge with reset_b high. No capture in IDLE.
- RUN, each edge: counter increments by 1. If memwrite and address==RESULT_ADDR: captured<=data, seen<=1, write_count increments (holds at 8'hFF).
- RUN -> DONE on the edge where counter==RUN_CYCLES-1. A matching write on that same edge is captured and included in the verdict.
- Verdict: pass=1 iff seen (including a final-edge write) and final captured==EXPECTED; otherwise fail=1. Exactly one of pass/fail is high when done=1; both 0 while done=0.
- DONE: all outputs frozen; further writes ignored; leave only via reset_b.
- Writes to other addresses, and reads, never affect state.
- Counter 16-bit, unsigned; it cannot wrap because the exit compare precedes overflow.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- captured/seen/write_count update on the edge a qualifying write is sampled; visible after that edge.
- done/pass/fail rise together exactly RUN_CYCLES+1 ph1 edges after reset_b release (1 IDLE edge + RUN_CYCLES RUN edges).
- Reset asserted mid-run or in DONE clears immediately, without waiting for a clock edge; re-release restarts the full window.

## Configuration
- RESULT_CHECKER_EARLY_PASS_EN defined: in RUN, a write to RESULT_ADDR with data==EXPECTED moves to DONE with pass=1 on that edge, ignoring the remaining window; a non-matching write does not end the run.
- Undefined: verdict only at window end, as specified above; a later overwrite of a correct value yields fail.

## Test plan
- Write 8'h7F to 16'h0015 at RUN cycle 50, no further writes -> after RUN_CYCLES+1 edges: done=1, pass=1, fail=0, captured=8'h7F, write_count=1.
- Write 8'h7F then 8'h00 to 16'h0015 (macro off) -> fail=1, captured=8'h00, write_count=2; with macro on -> pass=1 at the first write's edge, captured=8'h7F.
- No writes to 16'h0015, 300 writes to 16'h0014 -> fail=1, seen=0, captured=8'h00, write_count=0.
- Write 8'h7F to 16'h0015 exactly on the final RUN edge -> pass=1; same write one edge later (in DONE) -> ignored, fail=1.
- 300 writes to 16'h0015 with RUN_CYCLES=400 -> write_count=8'hFF.
- Assert reset_b low at RUN cycle 100 mid-window -> all outputs 0 immediately; after release, done rises again only after a full RUN_CYCLES+1 edges.

Source files
------------

// File: rtl/result_checker.sv
// result_checker: end-of-test checker snooping CPU bus writes.
// Captures the last byte written to RESULT_ADDR during a fixed run window and
// registers a sticky pass/fail verdict when the window closes.
// Optional feature macro: RESULT_CHECKER_EARLY_PASS_EN. When it is defined, a
// write of EXPECTED to RESULT_ADDR ends the run with pass on that edge.
module result_checker #(
  parameter logic [15:0] RESULT_ADDR = 16'h0015,
  parameter logic [7:0]  EXPECTED    = 8'h7F,
  parameter logic [15:0] RUN_CYCLES  = 16'd195
) (
  input  logic        ph1,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  captured,
  output logic        seen,
  output logic [7:0]  write_count
);

`ifdef RESULT_CHECKER_EARLY_PASS_EN
  localparam bit EarlyPassEn = 1'b1;
`else
  localparam bit EarlyPassEn = 1'b0;
`endif

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [7:0]  captured_q, captured_d;
  logic        seen_q, seen_d;
  logic [7:0]  wcount_q, wcount_d;
  logic        hit;

  assign hit = memwrite && (address == RESULT_ADDR);

  // Next-state: capture qualifying writes in RUN, close the window, form verdict.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    captured_d = captured_q;
    seen_d     = seen_q;
    wcount_d   = wcount_q;
    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        cnt_d = cnt_q + 16'd1;
        if (hit) begin
          captured_d = data;
          seen_d     = 1'b1;
          if (wcount_q != 8'hFF) wcount_d = wcount_q + 8'd1;
        end
        if (EarlyPassEn && hit && (data == EXPECTED)) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (cnt_q == RUN_CYCLES - 16'd1) begin
          // Verdict includes a write landing on this final edge.
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = seen_d && (captured_d == EXPECTED);
          fail_d  = !(seen_d && (captured_d == EXPECTED));
        end
      end
      default: ; // StDone: everything frozen until reset
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      captured_q <= 8'h00;
      seen_q     <= 1'b0;
      wcount_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      captured_q <= captured_d;
      seen_q     <= seen_d;
      wcount_q   <= wcount_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign captured    = captured_q;
  assign seen        = seen_q;
  assign write_count = wcount_q;

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: two instances (default window and a
// 400-cycle window) share stimulus; each is compared every cycle against an
// edge-indexed reference model of the checker's rules.
module tb_result_checker;

  localparam logic [15:0] RES_ADDR = 16'h0015;
  localparam logic [7:0]  EXP_VAL  = 8'h7F;
  localparam int          RC0      = 195;
  localparam int          RC1      = 400;

`ifdef RESULT_CHECKER_EARLY_PASS_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        ph1 = 1'b0;
  logic        reset_b;
  logic [15:0] address;
  logic [7:0]  data;
  logic        memwrite;

  logic       done0, pass0, fail0, seen0;
  logic [7:0] cap0, wc0;
  logic       done1, pass1, fail1, seen1;
  logic [7:0] cap1, wc1;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance, indexed by edges since reset release.
  int        m_edges [2];
  int        m_rc    [2];
  bit        m_done  [2];
  bit        m_pass  [2];
  bit        m_fail  [2];
  bit        m_seen  [2];
  bit [7:0]  m_cap   [2];
  int        m_wc    [2];

  always #5 ph1 = ~ph1;

  result_checker dut0 (
    .ph1(ph1), .reset_b(reset_b), .address(address), .data(data), .memwrite(memwrite),
    .done(done0), .pass(pass0), .fail(fail0), .captured(cap0), .seen(seen0),
    .write_count(wc0)
  );

  result_checker #(.RUN_CYCLES(16'd400)) dut1 (
    .ph1(ph1), .reset_b(reset_b), .address(address), .data(data), .memwrite(memwrite),
    .done(done1), .pass(pass1), .fail(fail1), .captured(cap1), .seen(seen1),
    .write_count(wc1)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_edges[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0;
      m_seen[i] = 0; m_cap[i] = 8'h00; m_wc[i] = 0;
    end
    m_rc[0] = RC0;
    m_rc[1] = RC1;
  endtask

  // First edge after release is idle; edge e>=2 is window cycle e-2.
  task automatic model_edge(input bit we, input logic [15:0] a, input logic [7:0] d);
    bit hit;
    hit = we && (a == RES_ADDR);
    for (int i = 0; i < 2; i++) begin
      if (!m_done[i]) begin
        if (m_edges[i] >= 1) begin
          if (hit) begin
            m_cap[i] = d;
            m_seen[i] = 1;
            m_wc[i] = (m_wc[i] >= 255) ? 255 : m_wc[i] + 1;
          end
          if (Early && hit && d == EXP_VAL) begin
            m_done[i] = 1; m_pass[i] = 1;
          end else if (m_edges[i] - 1 == m_rc[i] - 1) begin
            m_done[i] = 1;
            m_pass[i] = m_seen[i] && (m_cap[i] == EXP_VAL);
            m_fail[i] = !m_pass[i];
          end
        end
        m_edges[i]++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [19:0] obs0, obs1, exp0, exp1;
    obs0 = {done0, pass0, fail0, seen0, cap0, wc0};
    obs1 = {done1, pass1, fail1, seen1, cap1, wc1};
    exp0 = {m_done[0], m_pass[0], m_fail[0], m_seen[0], m_cap[0], 8'(m_wc[0])};
    exp1 = {m_done[1], m_pass[1], m_fail[1], m_seen[1], m_cap[1], 8'(m_wc[1])};
    checks++;
    if (obs0 !== exp0) begin
      errors++;
      $display("FAIL %s dut0 edge %0d: got {d,p,f,s,cap,wc}=%h required %h",
               tag, m_edges[0], obs0, exp0);
    end
    checks++;
    if (obs1 !== exp1) begin
      errors++;
      $display("FAIL %s dut1 edge %0d: got {d,p,f,s,cap,wc}=%h required %h",
               tag, m_edges[1], obs1, exp1);
    end
  endtask

  // Called at a negedge: drive inputs, take one rising edge, check at next negedge.
  task automatic step(input string tag, input bit we, input logic [15:0] a,
                      input logic [7:0] d);
    memwrite = we; address = a; data = d;
    @(posedge ph1);
    model_edge(we, a, d);
    @(negedge ph1);
    compare_all(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic start_run();
    @(negedge ph1);
    reset_b = 1'b0; memwrite = 1'b0; address = 16'h0; data = 8'h0;
    @(negedge ph1);
    reset_b = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge ph1);
    reset_b = 1'b0; memwrite = 1'b1; address = RES_ADDR; data = EXP_VAL;
    @(posedge ph1);
    #1;
    model_reset();
    compare_all("reset_held");
    start_run();
    compare_all("reset_release");
  endtask

  task automatic test_single_pass();
    start_run();
    for (int e = 1; e <= RC0 + 1; e++)
      if (e == 52) step("single", 1'b1, RES_ADDR, EXP_VAL);
      else step("single", 1'b0, RES_ADDR, 8'h00);
    checks++;
    if ({done0, pass0, fail0, cap0, wc0} !== {3'b110, 8'h7F, 8'd1}) begin
      errors++;
      $display("FAIL single_final: got %b%b%b cap=%h wc=%0d required 110 cap=7f wc=1",
               done0, pass0, fail0, cap0, wc0);
    end
  endtask

  task automatic test_overwrite();
    start_run();
    for (int e = 1; e <= RC0 + 1; e++)
      if (e == 32) step("overwrite", 1'b1, RES_ADDR, EXP_VAL);
      else if (e == 62) step("overwrite", 1'b1, RES_ADDR, 8'h00);
      else step("overwrite", 1'b0, 16'h0000, 8'h00);
    checks++;
    if (Early) begin
      if ({pass0, cap0} !== {1'b1, 8'h7F}) begin
        errors++;
        $display("FAIL overwrite_early: got pass=%b cap=%h required pass=1 cap=7f", pass0, cap0);
      end
    end else if ({fail0, cap0, wc0} !== {1'b1, 8'h00, 8'd2}) begin
      errors++;
      $display("FAIL overwrite: got fail=%b cap=%h wc=%0d required fail=1 cap=00 wc=2",
               fail0, cap0, wc0);
    end
  endtask

  task automatic test_other_addr();
    start_run();
    for (int e = 1; e <= 300; e++) step("other_addr", 1'b1, 16'h0014, EXP_VAL);
    checks++;
    if ({fail0, seen0, cap0, wc0} !== {1'b1, 1'b0, 8'h00, 8'd0}) begin
      errors++;
      $display("FAIL other_addr: got fail=%b seen=%b cap=%h wc=%0d required 1 0 00 0",
               fail0, seen0, cap0, wc0);
    end
  endtask

  // Writes EXPECTED on window cycle k only; k=RC0-1 is the final edge, k=RC0 is in DONE.
  task automatic test_edge_write(input int k, input bit want_pass);
    start_run();
    for (int e = 1; e <= RC0 + 3; e++)
      if (e == k + 2) step("edge_write", 1'b1, RES_ADDR, EXP_VAL);
      else step("edge_write", 1'b0, 16'h0000, 8'h00);
    checks++;
    if ({done0, pass0, fail0} !== {1'b1, want_pass, !want_pass}) begin
      errors++;
      $display("FAIL edge_write k=%0d: got dpf=%b%b%b required 1%b%b",
               k, done0, pass0, fail0, want_pass, !want_pass);
    end
  endtask

  task automatic test_saturate();
    start_run();
    for (int e = 1; e <= RC1 + 2; e++)
      if (e >= 2 && e <= 301) step("saturate", 1'b1, RES_ADDR, 8'($urandom_range(0, 126)));
      else step("saturate", 1'b0, 16'h0000, 8'h00);
    checks++;
    if ({done1, wc1} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL saturate: got done=%b wc=%h required done=1 wc=ff", done1, wc1);
    end
  endtask

  task automatic test_mid_reset();
    start_run();
    for (int e = 1; e <= 101; e++) step("mid_reset_pre", 1'b1, RES_ADDR, EXP_VAL ^ 8'h01);
    #2;
    reset_b = 1'b0;
    #1;
    model_reset();
    compare_all("mid_reset_async");
    @(negedge ph1);
    reset_b = 1'b1;
    for (int e = 1; e <= RC0 + 1; e++) begin
      step("mid_reset_post", 1'b0, 16'h0000, 8'h00);
      checks++;
      if (done0 !== (e == RC0 + 1)) begin
        errors++;
        $display("FAIL mid_reset_done edge %0d: got done=%b required %b", e, done0, e == RC0 + 1);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      start_run();
      for (int e = 1; e <= RC0 + 10; e++) begin
        logic [15:0] a;
        logic [7:0]  d;
        case ($urandom_range(0, 2))
          0: a = RES_ADDR;
          1: a = 16'h0014;
          default: a = 16'($urandom);
        endcase
        d = ($urandom_range(0, 3) == 0) ? EXP_VAL : 8'($urandom);
        step("random", ($urandom_range(0, 3) == 0), a, d);
      end
    end
  endtask

  initial begin
    reset_b = 1'b0; memwrite = 1'b0; address = 16'h0; data = 8'h0;
    model_reset();
    test_reset();
    test_single_pass();
    test_overwrite();
    test_other_addr();
    test_edge_write(RC0 - 1, 1'b1);
    test_edge_write(RC0, 1'b0);
    test_saturate();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
